// File: rtl/mux_scan_if.sv
// Bundle between the scan controller and its surroundings: request, mask, mux return, select and result word.
// Latency: none, wiring only.
// Backpressure: word_valid/word_ready handshake on the result word.
interface mux_scan_if;
    logic       start;
    logic [5:0] chan_en;
    logic       mux_y;
    logic [2:0] sel;
    logic [5:0] word;
    logic       word_valid;
    logic       word_ready;
    logic       busy;

    // Controller side
    modport master (
        input  start, chan_en, mux_y, word_ready,
        output sel, word, word_valid, busy
    );

    // Requester / mux / consumer side
    modport slave (
        output start, chan_en, mux_y, word_ready,
        input  sel, word, word_valid, busy
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps the 6:1 mux select over enabled channels, samples mux_y after SETTLE edges each, packs a 6-bit word.
// Latency: N*SETTLE edges from accepted start to word_valid (1 edge when no channel is enabled).
// Backpressure: word and sel are held in HOLD until word_ready; start is ignored outside IDLE.
module mux_scan_ctrl #(
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_scan_if.master      bus
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t     state_q, state_nxt;
    logic [2:0] sel_q, sel_nxt;
    logic [3:0] cnt_q, cnt_nxt;
    logic [5:0] en_q, en_nxt;
    logic [5:0] word_q, word_nxt;

    logic [2:0] first_idx;
    logic [2:0] next_idx;
    logic       next_vld;

    // Priority pick: lowest enabled channel in the incoming mask, and lowest latched channel above sel
    always_comb begin
        first_idx = 3'd0;
        next_idx  = 3'd0;
        next_vld  = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            if (bus.chan_en[i]) begin
                first_idx = 3'(i);
            end
            if (en_q[i] && (3'(i) > sel_q)) begin
                next_idx = 3'(i);
                next_vld = 1'b1;
            end
        end
    end

    // Next-state and datapath updates; everything holds unless the current state says otherwise
    always_comb begin
        state_nxt = state_q;
        sel_nxt   = sel_q;
        cnt_nxt   = cnt_q;
        en_nxt    = en_q;
        word_nxt  = word_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    en_nxt   = bus.chan_en;
                    word_nxt = 6'd0;
                    if (bus.chan_en != 6'd0) begin
                        sel_nxt   = first_idx;
                        cnt_nxt   = SETTLE_LD;
                        state_nxt = S_SETTLE;
                    end else begin
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_SETTLE: begin
                if (cnt_q > 4'd1) begin
                    cnt_nxt = cnt_q - 4'd1;
                end else begin
                    // Settle window elapsed: capture this channel, then advance or finish
                    word_nxt[sel_q] = bus.mux_y;
                    if (next_vld) begin
                        sel_nxt = next_idx;
                        cnt_nxt = SETTLE_LD;
                    end else begin
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.word_ready) begin
                    sel_nxt   = 3'd0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                sel_nxt   = 3'd0;
            end
        endcase
    end

    // State and datapath registers; reset drops any scan in flight and its partial word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= 3'd0;
            cnt_q   <= 4'd0;
            en_q    <= 6'd0;
            word_q  <= 6'd0;
        end else begin
            state_q <= state_nxt;
            sel_q   <= sel_nxt;
            cnt_q   <= cnt_nxt;
            en_q    <= en_nxt;
            word_q  <= word_nxt;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.word       = word_q;
    assign bus.word_valid = (state_q == S_HOLD);
    assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (SETTLE=2 and SETTLE=3) share one stimulus stream.
// Latency: checks every cycle against a timeline model of the scan.
// Backpressure: exercises word_ready stalls, ignored start and async reset.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [5:0] chan_en = 6'd0;
    logic       word_ready = 1'b0;
    logic [5:0] din = 6'd0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_scan_if bus2 ();
    mux_scan_if bus3 ();

    assign bus2.start      = start;
    assign bus2.chan_en    = chan_en;
    assign bus2.word_ready = word_ready;
    assign bus2.mux_y      = din[bus2.sel];
    assign bus3.start      = start;
    assign bus3.chan_en    = chan_en;
    assign bus3.word_ready = word_ready;
    assign bus3.mux_y      = din[bus3.sel];

    mux_scan_ctrl #(.SETTLE(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    mux_scan_ctrl #(.SETTLE(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    // DUT outputs gathered per instance (0: SETTLE=2, 1: SETTLE=3)
    logic [2:0] d_sel[2];
    logic [5:0] d_word[2];
    logic       d_vld[2];
    logic       d_busy[2];
    assign d_sel[0]  = bus2.sel;
    assign d_sel[1]  = bus3.sel;
    assign d_word[0] = bus2.word;
    assign d_word[1] = bus3.word;
    assign d_vld[0]  = bus2.word_valid;
    assign d_vld[1]  = bus3.word_valid;
    assign d_busy[0] = bus2.busy;
    assign d_busy[1] = bus3.busy;

    // ---------------- timeline model ----------------
    // phase: 0 idle, 1 scanning, 2 holding a word
    int         st[2] = '{2, 3};
    int         mph[2] = '{0, 0};
    int         e0[2] = '{0, 0};
    int         lst[2][6];
    int         lc[2] = '{0, 0};
    logic [5:0] mw[2] = '{6'd0, 6'd0};
    int         ms[2] = '{0, 0};
    int         cyc = 0;

    task automatic model_edge(input int d);
        int t;
        int k;
        case (mph[d])
            0: if (start) begin
                lc[d] = 0;
                for (int i = 0; i < 6; i++) begin
                    if (chan_en[i]) begin
                        lst[d][lc[d]] = i;
                        lc[d]++;
                    end
                end
                e0[d]  = cyc;
                mw[d]  = 6'd0;
                mph[d] = (lc[d] == 0) ? 2 : 1;
            end
            1: begin
                t = cyc - e0[d];
                if (t % st[d] == 0) begin
                    k = t / st[d] - 1;
                    mw[d][lst[d][k]] = din[lst[d][k]];
                    if (k == lc[d] - 1) mph[d] = 2;
                end
            end
            default: if (word_ready) mph[d] = 0;
        endcase
        case (mph[d])
            0:       ms[d] = 0;
            1:       ms[d] = lst[d][(cyc - e0[d]) / st[d]];
            default: ms[d] = (lc[d] == 0) ? 0 : lst[d][lc[d] - 1];
        endcase
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            for (int d = 0; d < 2; d++) model_edge(d);
        end
    end

    always @(negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            mph[d] = 0;
            mw[d]  = 6'd0;
            ms[d]  = 0;
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_assert++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, got, exp);
        end
    endtask

    // Per-cycle compare of both instances against the model
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("m%0d_sel", d),  int'(d_sel[d]),  ms[d]);
                chk($sformatf("m%0d_word", d), int'(d_word[d]), int'(mw[d]));
                chk($sformatf("m%0d_vld", d),  int'(d_vld[d]),  (mph[d] == 2) ? 1 : 0);
                chk($sformatf("m%0d_busy", d), int'(d_busy[d]), (mph[d] != 0) ? 1 : 0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_both_valid(input string nm);
        int n;
        n = 0;
        while (!(bus2.word_valid && bus3.word_valid) && n < 60) begin
            tick();
            n++;
        end
        chk({nm, "_timeout"}, int'(bus2.word_valid && bus3.word_valid), 1);
    endtask

    task automatic release_word();
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        chk("rel_busy2", int'(bus2.busy), 0);
        chk("rel_busy3", int'(bus3.busy), 0);
        chk("rel_sel2", int'(bus2.sel), 0);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_sel",  int'(bus2.sel), 0);
        chk("rst_word", int'(bus2.word), 0);
        chk("rst_vld",  int'(bus2.word_valid), 0);
        chk("rst_busy", int'(bus3.busy), 0);
        rst_n = 1'b1;
        tick();

        // Full mask, SETTLE=2: sel steps 0..5 two cycles each, valid after 12
        chan_en = 6'b111111;
        din     = 6'b101101;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 12; j++) begin
            chk($sformatf("t1_sel_%0d", j), int'(bus2.sel), j / 2);
            if (j == 11) chk("t1_vld_early", int'(bus2.word_valid), 0);
            tick();
        end
        chk("t1_vld",  int'(bus2.word_valid), 1);
        chk("t1_word", int'(bus2.word), 6'b101101);
        wait_both_valid("t1");
        chk("t1_word3", int'(bus3.word), 6'b101101);
        release_word();

        // Sparse mask, SETTLE=3: only 1 then 4; mask changes mid-scan are ignored
        chan_en = 6'b010010;
        din     = 6'b111111;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        chan_en = 6'b101101;
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("t2_sel_%0d", j), int'(bus3.sel), (j < 3) ? 1 : 4);
            tick();
        end
        chk("t2_vld",  int'(bus3.word_valid), 1);
        chk("t2_word", int'(bus3.word), 6'b010010);
        release_word();

        // Empty mask: valid one edge after start, word 0, sel 0
        chan_en = 6'b000000;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_vld2",  int'(bus2.word_valid), 1);
        chk("t3_vld3",  int'(bus3.word_valid), 1);
        chk("t3_word",  int'(bus2.word), 0);
        chk("t3_sel",   int'(bus3.sel), 0);
        release_word();

        // Backpressure in HOLD with start pulses and input churn
        chan_en = 6'b111111;
        din     = 6'b101101;
        start   = 1'b1;
        tick();
        start = 1'b0;
        wait_both_valid("t4");
        for (int j = 0; j < 5; j++) begin
            start   = (j == 2);
            din     = ~din;
            chan_en = 6'(j);
            tick();
            chk("t4_word", int'(bus2.word), 6'b101101);
            chk("t4_sel",  int'(bus3.sel), 5);
            chk("t4_vld",  int'(bus2.word_valid & bus3.word_valid), 1);
        end
        start = 1'b0;
        release_word();
        tick();
        chk("t4_nostart", int'(bus2.busy | bus3.busy), 0);

        // Async reset during the third channel
        chan_en = 6'b111111;
        din     = 6'b101101;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("t5_sel_pre", int'(bus2.sel), 2);
        rst_n = 1'b0;
        #1;
        chk("t5_sel",  int'(bus2.sel | bus3.sel), 0);
        chk("t5_word", int'(bus2.word | bus3.word), 0);
        chk("t5_vld",  int'(bus2.word_valid | bus3.word_valid), 0);
        chk("t5_busy", int'(bus2.busy | bus3.busy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        din   = 6'b000011;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_both_valid("t5");
        chk("t5_word2", int'(bus2.word), 6'b000011);
        chk("t5_word3", int'(bus3.word), 6'b000011);

        // Handshake and start on the same edge: only the handshake counts
        word_ready = 1'b1;
        start      = 1'b1;
        din        = 6'b110100;
        tick();
        word_ready = 1'b0;
        chk("t6_idle", int'(bus2.busy | bus3.busy), 0);
        chk("t6_vld",  int'(bus2.word_valid), 0);
        tick();
        start = 1'b0;
        chk("t6_busy", int'(bus2.busy & bus3.busy), 1);
        tick();
        chan_en = 6'b000001;
        wait_both_valid("t6");
        chk("t6_word2", int'(bus2.word), 6'b110100);
        chk("t6_word3", int'(bus3.word), 6'b110100);
        release_word();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencing controller for the 6:1 channel multiplexer. On a start request it drives the mux select through every enabled channel in ascending order, waits a programmable settle time per channel, samples the mux output bit, and assembles the six samples into one parallel word. The word is offered downstream on a valid/ready handshake. The block sits on both sides of the mux: it feeds the select and consumes the mux output.

## Interface
- SETTLE, 2, number of clock edges each select value is held before the mux output is sampled; legal range 1..15 (4-bit counter).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  scan request; honoured only in IDLE.
- chan_en  in  6  channel enable mask; bit i enables channel i; latched on accepted start.
- mux_y  in  1  output of the 6:1 mux.
- sel  out  3  select to the mux; values 0..5 only.
- word  out  6  assembled sample word; bit i = sample of channel i, 0 if channel disabled.
- word_valid  out  1  word is complete and stable.
- word_ready  in  1  downstream accepts word.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, SETTLE, HOLD.
- IDLE: sel=0, busy=0, word_valid=0. start=1 at an edge: latch chan_en into en_q, clear word. If the mask is nonzero, load sel with the lowest enabled index, load cnt=SETTLE, and go to SETTLE. If the mask is 0, go directly to HOLD with word=0.
- SETTLE: each edge with cnt>1 decrements cnt. The edge with cnt==1 writes word[sel]<=mux_y. If a higher enabled channel remains in en_q, sel<=next enabled index, cnt<=SETTLE, and the state stays SETTLE. Otherwise the state goes to HOLD and sel holds its last value.
- HOLD: word_valid=1. word and sel are stable. An edge with word_ready=1 goes to IDLE, sets sel<=0, and keeps word (word is cleared only by the next accepted start).
- start is ignored in SETTLE and HOLD, including an edge where word_ready=1. A new scan requires start in IDLE.
- Changes to chan_en after it is latched have no effect on the scan in progress.
- Disabled channels are never selected. Their word bits read 0.
- sel never takes the values 6 or 7.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, sel=0, word=0, word_valid=0, busy=0, cnt=0, en_q=0.
- Reset asserted mid-scan or in HOLD aborts the scan immediately and discards the partial word. After rst_n rises, the block waits in IDLE for start.
- Let N be the number of enabled channels and E0 the edge where start is accepted:
  - sel for channel k (k=0..N-1 in enable order) is valid from edge E0+k*SETTLE.
  - The sample of channel k is taken at edge E0+(k+1)*SETTLE.
  - word_valid rises after edge E0+N*SETTLE.
  - With N=0, word_valid rises after E0.
- mux_y is sampled at least SETTLE cycles after the matching sel change.
- Minimum turnaround: a HOLD->IDLE edge followed by a start edge gives a start-to-start distance of N*SETTLE+2 edges.
- busy rises after E0 and falls after the word_ready handshake edge.

## Test plan
- SETTLE=2, chan_en=6'b111111, mux model din=6'b101101:
  - sel steps 0,1,2,3,4,5, each held 2 cycles.
  - word_valid rises 12 cycles after start with word=6'b101101.
  - word_ready=1 returns the block to IDLE with sel=0.
- SETTLE=3, chan_en=6'b010010, din=6'b111111:
  - sel visits only 1 then 4.
  - word=6'b010010 is valid 6 cycles after start.
- chan_en=6'b000000, start pulse:
  - word_valid=1 one cycle later with word=0.
  - sel stays 0.
- Backpressure in HOLD: hold word_ready=0 for 5 cycles, pulse start, and change mux_y/chan_en.
  - word, sel and word_valid stay unchanged.
  - No new scan starts.
  - word_ready=1 then returns the block to IDLE.
- Reset mid-scan: drop rst_n during the third channel.
  - sel, word, word_valid and busy go to 0 without waiting for a clock edge.
  - After release, a fresh start with din=6'b000011 and full mask yields word=6'b000011.
- Interleaving: in HOLD, assert word_ready and start on the same edge.
  - Only the handshake completes and the block enters IDLE.
  - start on the next edge begins a scan.
  - Toggling chan_en mid-scan does not alter the visited channels.
